// File: rtl/ordena_n.sv
// Sequential N x W unsigned sorter: odd-even transposition, one compare-swap phase per clock.
// Optional early exit on two consecutive swap-free phases is enabled by defining ORDENA_EARLY_EXIT_EN.
module ordena_n #(
  parameter int N = 9,
  parameter int W = 8
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic                     start,
  input  logic                     modo,
  input  logic [W-1:0]             entrada [N],
  output logic [W-1:0]             saida   [N],
  output logic                     busy,
  output logic                     flag,
  output logic [$clog2(N+1)-1:0]   ciclos
);

  localparam int CW = $clog2(N+1);

  typedef enum logic [1:0] {IDLE = 2'd0, SORT = 2'd1, DONE = 2'd2} state_t;

  state_t          state, state_nxt;
  logic [W-1:0]    arr [N];
  logic [W-1:0]    net [N];
  logic            modo_r;
  logic [CW-1:0]   cnt;
  logic            load;
  logic            fin;
  logic            last;
`ifdef ORDENA_EARLY_EXIT_EN
  logic            swp;
  logic            quiet_r;
`endif

  // Strict compare: equal elements never move, so duplicates keep their order.
  function automatic logic must_swap(input logic desc, input logic [W-1:0] a, input logic [W-1:0] b);
    return desc ? (a < b) : (a > b);
  endfunction

  // One transposition phase; cnt[0] selects even (0,1),(2,3).. or odd (1,2),(3,4).. pairs.
  always_comb begin
    net = arr;
`ifdef ORDENA_EARLY_EXIT_EN
    swp = 1'b0;
`endif
    for (int i = 0; i < N - 1; i++) begin
      if (((i % 2) == 1) == cnt[0] && must_swap(modo_r, arr[i], arr[i+1])) begin
        net[i]   = arr[i+1];
        net[i+1] = arr[i];
`ifdef ORDENA_EARLY_EXIT_EN
        swp = 1'b1;
`endif
      end
    end
  end

`ifdef ORDENA_EARLY_EXIT_EN
  assign last = (cnt == CW'(N - 1)) || (quiet_r && !swp);
`else
  assign last = (cnt == CW'(N - 1));
`endif

  always_comb begin
    state_nxt = state;
    load      = 1'b0;
    fin       = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          load      = 1'b1;
          state_nxt = SORT;
        end
      end
      SORT: begin
        if (last) begin
          fin       = 1'b1;
          state_nxt = DONE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= IDLE;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < N; i++) begin
        arr[i]   <= '0;
        saida[i] <= '0;
      end
      modo_r <= 1'b0;
      cnt    <= '0;
      ciclos <= '0;
`ifdef ORDENA_EARLY_EXIT_EN
      quiet_r <= 1'b0;
`endif
    end else if (load) begin
      arr    <= entrada;
      modo_r <= modo;
      cnt    <= '0;
`ifdef ORDENA_EARLY_EXIT_EN
      quiet_r <= 1'b0;
`endif
    end else if (state == SORT) begin
      arr <= net;
      cnt <= cnt + CW'(1);
`ifdef ORDENA_EARLY_EXIT_EN
      quiet_r <= !swp;
`endif
      // Result becomes visible only here; intermediate phases stay internal.
      if (fin) begin
        saida  <= net;
        ciclos <= cnt + CW'(1);
      end
    end
  end

  assign busy = (state == SORT);
  assign flag = (state == DONE);

endmodule

// File: tb/tb_ordena_n.sv
// Directed and reference-model bench for ordena_n at N=9/W=8, N=2/W=16 and N=16/W=4.
module tb_ordena_n;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       reset;
  logic       start9, modo9, busy9, flag9;
  logic [7:0] ent9 [9];
  logic [7:0] sai9 [9];
  logic [3:0] cic9;

  logic        start2, modo2, busy2, flag2;
  logic [15:0] ent2 [2];
  logic [15:0] sai2 [2];
  logic [1:0]  cic2;

  logic       start16, modo16, busy16, flag16;
  logic [3:0] ent16 [16];
  logic [3:0] sai16 [16];
  logic [4:0] cic16;

  ordena_n #(.N(9), .W(8)) dut9 (
    .clk(clk), .reset(reset), .start(start9), .modo(modo9), .entrada(ent9),
    .saida(sai9), .busy(busy9), .flag(flag9), .ciclos(cic9));

  ordena_n #(.N(2), .W(16)) dut2 (
    .clk(clk), .reset(reset), .start(start2), .modo(modo2), .entrada(ent2),
    .saida(sai2), .busy(busy2), .flag(flag2), .ciclos(cic2));

  ordena_n #(.N(16), .W(4)) dut16 (
    .clk(clk), .reset(reset), .start(start16), .modo(modo16), .entrada(ent16),
    .saida(sai16), .busy(busy16), .flag(flag16), .ciclos(cic16));

  int n_vec = 0;
  int n_err = 0;

  logic [7:0] v_a    [9] = '{8'd5, 8'd3, 8'd8, 8'd1, 8'd9, 8'd2, 8'd7, 8'd4, 8'd6};
  logic [7:0] v_b    [9] = '{8'h10, 8'hFF, 8'h00, 8'h7F, 8'h80, 8'h01, 8'h10, 8'hFE, 8'h02};
  logic [7:0] v_b_ds [9] = '{8'hFF, 8'hFE, 8'h80, 8'h7F, 8'h10, 8'h10, 8'h02, 8'h01, 8'h00};
  logic [7:0] v_asc  [9] = '{8'd1, 8'd2, 8'd3, 8'd4, 8'd5, 8'd6, 8'd7, 8'd8, 8'd9};
  logic [7:0] v_rev  [9] = '{8'd9, 8'd8, 8'd7, 8'd6, 8'd5, 8'd4, 8'd3, 8'd2, 8'd1};
  logic [7:0] v_zero [9] = '{default: 8'd0};

  task automatic check(input string tag, input logic [255:0] got, input logic [255:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  function automatic logic [255:0] p9(input logic [7:0] a [9]);
    logic [255:0] r = '0;
    for (int i = 0; i < 9; i++) r[i*8 +: 8] = a[i];
    return r;
  endfunction

  function automatic logic [255:0] p16(input logic [3:0] a [16]);
    logic [255:0] r = '0;
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = a[i];
    return r;
  endfunction

  // Insertion sort reference, then packed in the requested order.
  function automatic logic [255:0] ref16(input logic [3:0] a [16], input logic desc);
    int v [16];
    int t, j;
    logic [255:0] r = '0;
    for (int i = 0; i < 16; i++) v[i] = int'(a[i]);
    for (int i = 1; i < 16; i++) begin
      t = v[i];
      j = i - 1;
      while (j >= 0 && v[j] > t) begin
        v[j+1] = v[j];
        j--;
      end
      v[j+1] = t;
    end
    for (int i = 0; i < 16; i++) r[i*4 +: 4] = 4'(desc ? v[15-i] : v[i]);
    return r;
  endfunction

  task automatic go9(input logic m);
    modo9  = m;
    start9 = 1'b1;
    tick();
    start9 = 1'b0;
  endtask

  task automatic wait9(output int e, output int bc);
    e  = 0;
    bc = 0;
    while (!flag9 && e < 20) begin
      if (busy9) bc++;
      tick();
      e++;
    end
  endtask

  task automatic check_lat9(input string tag, input int e, input int full);
`ifdef ORDENA_EARLY_EXIT_EN
    check(tag, (e >= 2 && e <= full), 1);
`else
    check(tag, e, full);
`endif
  endtask

  initial begin
    int e, bc, e2;
    logic [255:0] prev;
    logic [15:0] lo, hi;

    reset = 1'b1; start9 = 1'b1; modo9 = 1'b0; ent9 = v_a;
    start2 = 1'b0; modo2 = 1'b0; ent2 = '{default: 16'd0};
    start16 = 1'b0; modo16 = 1'b0; ent16 = '{default: 4'd0};
    tick();
    tick();
    check("rst_busy", busy9, 0);
    check("rst_flag", flag9, 0);
    check("rst_ciclos", cic9, 0);
    check("rst_saida", p9(sai9), p9(v_zero));
    reset = 1'b0; start9 = 1'b0;
    tick();
    check("rst_start_dropped", busy9, 0);

    // Ascending basic sort with latency and busy window.
    ent9 = v_a;
    go9(1'b0);
    check("t1_busy_at_start", busy9, 1);
    check("t1_flag_at_start", flag9, 0);
    wait9(e, bc);
    check_lat9("t1_latency", e, 9);
    check("t1_busy_cycles", bc, e);
    check("t1_saida", p9(sai9), p9(v_asc));
    check("t1_busy_end", busy9, 0);
`ifdef ORDENA_EARLY_EXIT_EN
    check("t1_ciclos", cic9, e);
`else
    check("t1_ciclos", cic9, 9);
`endif

    // Pre-sorted input.
    ent9 = v_asc;
    go9(1'b0);
    wait9(e, bc);
`ifdef ORDENA_EARLY_EXIT_EN
    check("t3_latency", e, 2);
    check("t3_ciclos", cic9, 2);
`else
    check("t3_latency", e, 9);
    check("t3_ciclos", cic9, 9);
`endif
    check("t3_saida", p9(sai9), p9(v_asc));

    // Descending with duplicates.
    ent9 = v_b;
    go9(1'b1);
    wait9(e, bc);
    check_lat9("t2_latency", e, 9);
    check("t2_saida", p9(sai9), p9(v_b_ds));

    // Restart from DONE: flag drops, old result held until completion.
    prev = p9(sai9);
    ent9 = v_rev;
    go9(1'b0);
    check("t5_flag_drop", flag9, 0);
    e = 0;
    while (!flag9 && e < 20) begin
      check("t5_saida_held", p9(sai9), prev);
      tick();
      e++;
    end
    check_lat9("t5_latency", e, 9);
    check("t5_saida", p9(sai9), p9(v_asc));

    // Start during SORT is ignored; entrada/modo changes have no effect.
    ent9 = v_a;
    go9(1'b1);
    tick();
    tick();
    ent9 = v_asc; modo9 = 1'b0; start9 = 1'b1;
    tick();
    start9 = 1'b0;
    ent9 = v_b;
    wait9(e, bc);
    check_lat9("t4_latency", e + 3, 9);
    check("t4_saida", p9(sai9), p9(v_rev));

    // Reset mid-sort aborts without exposing anything.
    ent9 = v_b;
    go9(1'b0);
    tick();
    tick();
    ent9 = v_rev; start9 = 1'b1;
    tick();
    start9 = 1'b0;
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    check("t4r_busy", busy9, 0);
    check("t4r_flag", flag9, 0);
    check("t4r_saida", p9(sai9), p9(v_zero));
    tick(); tick(); tick();
    check("t4r_idle_flag", flag9, 0);
    check("t4r_idle_busy", busy9, 0);
    ent9 = v_a;
    go9(1'b0);
    wait9(e, bc);
    check_lat9("t4r_latency", e, 9);
    check("t4r_saida", p9(sai9), p9(v_asc));

    // N=2, W=16 random runs in both modes.
    for (int r = 0; r < 2000; r++) begin
      ent2[0] = 16'($urandom_range(0, 65535));
      ent2[1] = (r % 7 == 0) ? ent2[0] : 16'($urandom_range(0, 65535));
      modo2 = r[0];
      lo = (ent2[0] < ent2[1]) ? ent2[0] : ent2[1];
      hi = (ent2[0] < ent2[1]) ? ent2[1] : ent2[0];
      start2 = 1'b1;
      tick();
      start2 = 1'b0;
      e2 = 0;
      while (!flag2 && e2 < 10) begin
        tick();
        e2++;
      end
      check("n2_latency", e2, 2);
      check("n2_ciclos", cic2, 2);
      if (modo2) check("n2_desc", {sai2[0], sai2[1]}, {hi, lo});
      else       check("n2_asc",  {sai2[0], sai2[1]}, {lo, hi});
    end

    // N=16, W=4 random runs in both modes.
    for (int r = 0; r < 2000; r++) begin
      for (int i = 0; i < 16; i++) ent16[i] = 4'($urandom_range(0, 15));
      modo16 = r[0];
      start16 = 1'b1;
      tick();
      start16 = 1'b0;
      e2 = 0;
      while (!flag16 && e2 < 40) begin
        tick();
        e2++;
      end
`ifdef ORDENA_EARLY_EXIT_EN
      check("n16_ciclos", (cic16 >= 2 && cic16 <= 16 && int'(cic16) == e2), 1);
`else
      check("n16_ciclos", cic16, 16);
      check("n16_latency", e2, 16);
`endif
      check("n16_saida", p16(sai16), ref16(ent16, modo16));
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
